microcode_sequencer: RTL and testbench

//  Micro-program sequencer that feeds the per-core control-signal decoder. Holds the micro-PC,

---
 rtl/microcode_sequencer_pkg.sv | 23 ++
 rtl/microcode_sequencer_counter.sv | 36 +++
 rtl/microcode_sequencer.sv | 119 +++++++++++
 tb/tb_microcode_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the micro-program sequencer, its decoder and the ROM model.
package microcode_sequencer_pkg;

  // Default geometry of the micro-program store.
  localparam int UC_ADDR_W     = 5;
  localparam int UC_WORD_W     = 35;
  localparam int UC_START_ADDR = 0;
  localparam int UC_HALT_ADDR  = 31;
  localparam int UC_CNT_W      = 16;

  // Sequencer state encodings. Five states need three bits.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // True while a micro-program is actively being fetched or executed.
  function automatic logic state_is_busy(input logic [2:0] st);
    return (st == S_FETCH) || (st == S_LATCH) || (st == S_WAIT);
  endfunction

endpackage

// File: rtl/microcode_sequencer_counter.sv
// Saturating counter of retired microinstructions. Named useq_counter for reuse by the decoder team.
module useq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-program sequencer: owns the micro-PC, addresses the sync ROM, registers the
// fetched word for the decoder and advances on the decoder's NXTADD.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int ADDR_W     = UC_ADDR_W,
  parameter int WORD_W     = UC_WORD_W,
  parameter int START_ADDR = UC_START_ADDR,
  parameter int HALT_ADDR  = UC_HALT_ADDR,
  parameter int CNT_W      = UC_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] romin,
  output logic              romin_valid,
  input  logic [ADDR_W-1:0] nxt_add,
  input  logic              nxt_valid,
  output logic              busy,
  output logic              done,
  output logic              seq_err,
  output logic [CNT_W-1:0]  uinst_cnt
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] HALT_PC  = ADDR_W'(HALT_ADDR);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [WORD_W-1:0] romin_q, romin_d;
  logic              seq_err_q, seq_err_d;
  logic              cnt_clr;
  logic              cnt_en;

  // Next-state logic; a stalled cycle leaves every register untouched.
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    romin_d   = romin_q;
    seq_err_d = seq_err_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    if (!stall) begin
      // NXTADD arriving when no word is outstanding means the decoder lost sync.
      if (nxt_valid && (state_q != S_WAIT)) begin
        seq_err_d = 1'b1;
      end
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_d = S_FETCH;
            upc_d   = START_PC;
            cnt_clr = 1'b1;
          end
        end
        S_FETCH: begin
          // ROM access cycle: address presented, data arrives next cycle.
          state_d = S_LATCH;
        end
        S_LATCH: begin
          romin_d = rom_data;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // start is ignored here, so nxt_valid naturally wins.
          if (nxt_valid) begin
            cnt_en = 1'b1;
            if (nxt_add == HALT_PC) begin
              state_d = S_HALT;
            end else begin
              upc_d   = nxt_add;
              state_d = S_FETCH;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sequencer state registers; reset aborts any program and clears romin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      upc_q     <= START_PC;
      romin_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      romin_q   <= romin_d;
      seq_err_q <= seq_err_d;
    end
  end

  useq_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_i (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (uinst_cnt)
  );

  // romin_valid marks the LATCH cycle; a stall suppresses it until LATCH really completes.
  assign romin_valid = (state_q == S_LATCH) && !stall;
  assign rom_addr    = upc_q;
  assign romin       = romin_q;
  assign busy        = state_is_busy(state_q);
  assign done        = (state_q == S_HALT);
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a synchronous ROM model.
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  rom_addr;
  logic [34:0] rom_data = '0;
  logic [34:0] romin;
  logic        romin_valid;
  logic [4:0]  nxt_add = '0;
  logic        nxt_valid = 1'b0;
  logic        busy;
  logic        done;
  logic        seq_err;
  logic [15:0] uinst_cnt;

  // Second instance with a narrow counter to reach saturation quickly.
  logic        start2 = 1'b0;
  logic        stall2 = 1'b0;
  logic [4:0]  rom_addr2;
  logic [34:0] rom_data2 = '0;
  logic [34:0] romin2;
  logic        romin_valid2;
  logic [4:0]  nxt_add2 = '0;
  logic        nxt_valid2 = 1'b0;
  logic        busy2;
  logic        done2;
  logic        seq_err2;
  logic [5:0]  uinst_cnt2;

  logic [34:0] rom [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom[rom_addr2];
  end

  microcode_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .romin       (romin),
    .romin_valid (romin_valid),
    .nxt_add     (nxt_add),
    .nxt_valid   (nxt_valid),
    .busy        (busy),
    .done        (done),
    .seq_err     (seq_err),
    .uinst_cnt   (uinst_cnt)
  );

  microcode_sequencer #(.CNT_W(6)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .stall       (stall2),
    .rom_addr    (rom_addr2),
    .rom_data    (rom_data2),
    .romin       (romin2),
    .romin_valid (romin_valid2),
    .nxt_add     (nxt_add2),
    .nxt_valid   (nxt_valid2),
    .busy        (busy2),
    .done        (done2),
    .seq_err     (seq_err2),
    .uinst_cnt   (uinst_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH: walks FETCH -> LATCH -> WAIT and checks the latched word.
  task automatic fetch_word(input logic [4:0] addr);
    check($sformatf("rom_addr@fetch%0d", addr), rom_addr, addr);
    tick();
    check($sformatf("valid@latch%0d", addr), romin_valid, 1);
    tick();
    check($sformatf("romin@wait%0d", addr), romin, rom[addr]);
    check($sformatf("valid@wait%0d", addr), romin_valid, 0);
  endtask

  task automatic ret(input logic [4:0] nxt);
    nxt_add   = nxt;
    nxt_valid = 1'b1;
    tick();
    nxt_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 35'h1_0000_0000 + 35'(i) * 35'h0_0101_0303;
    rom[9] = 35'h5A5A5A5A5;

    // Reset state
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_romin", romin, 0);
    check("rst_valid", romin_valid, 0);
    check("rst_seqerr", seq_err, 0);
    check("rst_cnt", uinst_cnt, 0);
    check("rst_addr", rom_addr, 0);
    reset = 1'b0;
    tick();

    // Program 0 -> 3 -> 7 -> halt, with an ignored start in WAIT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy@fetch", busy, 1);
    fetch_word(5'd0);
    ret(5'd3);
    check("cnt_after1", uinst_cnt, 1);
    fetch_word(5'd3);
    ret(5'd7);
    fetch_word(5'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wait_start_addr", rom_addr, 7);
    check("wait_start_busy", busy, 1);
    check("wait_start_valid", romin_valid, 0);
    ret(5'd31);
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_cnt", uinst_cnt, 3);
    check("halt_addr", rom_addr, 7);
    tick();
    check("halt_addr_hold", rom_addr, 7);

    // Restart from HALT, then stall across LATCH
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_cnt", uinst_cnt, 0);
    check("restart_addr", rom_addr, 0);
    tick();
    check("restart_latency", romin_valid, 1);
    stall = 1'b1;
    #1;
    check("stall_valid0", romin_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_valid", i), romin_valid, 0);
      check($sformatf("stall%0d_romin", i), romin, rom[7]);
    end
    stall = 1'b0;
    #1;
    check("unstall_valid", romin_valid, 1);
    tick();
    check("unstall_romin", romin, rom[0]);
    check("unstall_cnt", uinst_cnt, 0);
    stall = 1'b1;
    nxt_add = 5'd5;
    nxt_valid = 1'b1;
    tick();
    check("stall_nxt_cnt", uinst_cnt, 0);
    check("stall_nxt_addr", rom_addr, 0);
    stall = 1'b0;
    ret(5'd31);
    check("halt2_done", done, 1);
    check("halt2_cnt", uinst_cnt, 1);

    // nxt_valid in IDLE sets sticky seq_err
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    check("idle_seqerr0", seq_err, 0);
    nxt_add = 5'd6;
    nxt_valid = 1'b1;
    tick();
    nxt_valid = 1'b0;
    check("idle_seqerr1", seq_err, 1);
    check("idle_busy", busy, 0);
    check("idle_addr", rom_addr, 0);

    // Reach WAIT holding 0x5A5A5A5A5, then async reset without a clock edge
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch_word(5'd0);
    ret(5'd9);
    fetch_word(5'd9);
    check("seqerr_sticky", seq_err, 1);
    reset = 1'b1;
    #1;
    check("async_romin", romin, 0);
    check("async_done", done, 0);
    check("async_busy", busy, 0);
    check("async_seqerr", seq_err, 0);
    check("async_cnt", uinst_cnt, 0);
    tick();
    reset = 1'b0;
    tick();

    // Micro-loop at address 4 on the 6-bit counter instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 70; i++) begin
      nxt_add2   = 5'd4;
      nxt_valid2 = 1'b1;
      tick();
      nxt_valid2 = 1'b0;
      tick();
      tick();
      if (i == 1)  check("loop_cnt1", uinst_cnt2, 1);
      if (i == 63) check("loop_cnt63", uinst_cnt2, 63);
    end
    check("loop_sat", uinst_cnt2, 6'h3F);
    check("loop_addr", rom_addr2, 4);
    check("loop_romin", romin2, rom[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
